redund_port_sel: RTL and testbench

//  N-way redundant-port selector with automatic failover; replaces the fixed GPIO mux_select bit.

---
 rtl/redund_port_sel_pkg.sv | 17 +
 rtl/redund_port_sel_holdoff_timer.sv | 38 +++
 rtl/redund_port_sel.sv | 198 +++++++++++++++++++
 tb/tb_redund_port_sel.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/redund_port_sel_pkg.sv
// Shared state encoding and default timing constant for the redundant-port selector.
// No logic; imported by redund_port_sel and holdoff_timer.
// State codes are fixed 3-bit values so they can be decoded on a debug bus.
package redund_port_sel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SWITCH = 3'd4
    } state_t;

    // Link-loss debounce: 10 ms at an 8 ns clock.
    localparam int unsigned HOLDOFF_DEFAULT = 32'd1250000;

endpackage

// File: rtl/redund_port_sel_holdoff_timer.sv
// Debounce timer shared by link-loss holdoff and revert qualification.
// Latency: expired rises once CYCLES consecutive enabled cycles have elapsed (the CYCLES-th cycle).
// Backpressure: none; clear has priority over enable, count saturates at CYCLES.
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : zero the count
//  enable     : advance the count by one this cycle
//  expired    : count has reached CYCLES-1, i.e. this is the CYCLES-th enabled cycle
module holdoff_timer
    import redund_port_sel_pkg::*;
#(
    parameter int unsigned CYCLES = HOLDOFF_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != W'(CYCLES))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Independent of enable so the consuming FSM has no combinational loop
    // through this module; the FSM only looks at it while it is enabling.
    assign expired = (cnt >= W'(CYCLES - 1));

endmodule

// File: rtl/redund_port_sel.sv
// N-way redundant port selector: moves the upstream path to a healthy port on link loss.
// Latency: link loss to sel change = HOLDOFF_CYCLES + drain time + 2 cycles; all outputs registered.
// Backpressure: a switch waits in DRAIN until busy=0, so a frame in flight is never cut.
//  Ports: clk, rst_n (async active-low); link[NUM_PORTS] per-port link up; busy = packet in flight;
//         manual_en/manual_sel software override; sel/sel_onehot active port; fifo_rst per-port
//         pkt_fifo reset; no_link = no port up; switch_pulse/switch_cnt completed switches.
//  Build option: define REDUND_REVERT_EN for revertive mode (return to port 0 once it is stable).
module redund_port_sel
    import redund_port_sel_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned SEL_W          = 3,
    parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] link,
    input  logic                 busy,
    input  logic                 manual_en,
    input  logic [SEL_W-1:0]     manual_sel,
    output logic [SEL_W-1:0]     sel,
    output logic [NUM_PORTS-1:0] sel_onehot,
    output logic [NUM_PORTS-1:0] fifo_rst,
    output logic                 no_link,
    output logic                 switch_pulse,
    output logic [CNT_W-1:0]     switch_cnt
);

    function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        to_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (32'(idx) == i) to_onehot[i] = 1'b1;
        end
    endfunction

    // Lowest set bit; returns 0 for an empty vector (callers gate with |v).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SEL_W'(i);
        end
    endfunction

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     tgt_q, tgt_d;
    logic [SEL_W-1:0]     sel_q;
    logic [NUM_PORTS-1:0] onehot_q;
    logic [NUM_PORTS-1:0] fifo_rst_q;
    logic                 no_link_q;
    logic                 pulse_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 tmr_clr, tmr_en, tmr_exp;

    logic                 manual_ok;
    logic                 sel_up;
    logic                 tgt_lost;
    logic [NUM_PORTS-1:0] other_up;
    logic                 cand_any;
    logic [SEL_W-1:0]     cand;
    logic [SEL_W-1:0]     idle_cand;

    assign manual_ok = manual_en && (32'(manual_sel) < NUM_PORTS);
    assign sel_up    = |(link & to_onehot(sel_q));
    assign other_up  = link & ~to_onehot(sel_q);
    assign cand_any  = manual_ok || (|other_up);
    assign cand      = manual_ok ? manual_sel : lowest_set(other_up);
    // From IDLE the previous port is a legitimate choice again.
    assign idle_cand = manual_ok ? manual_sel : lowest_set(link);

    // A manual target without link is a deliberate diagnostic switch, so it
    // is not treated as lost while the request is still asserted.
    assign tgt_lost  = !(|(link & to_onehot(tgt_q))) && !(manual_ok && (manual_sel == tgt_q));

    holdoff_timer #(
        .CYCLES (HOLDOFF_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .expired (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|link) begin
                    state_d = ST_SWITCH;
                    tgt_d   = idle_cand;
                end
            end
            ST_ACTIVE: begin
                // Link loss outranks any manual or revert request.
                if (!sel_up) begin
                    state_d = ST_HOLD;
                end else if (manual_ok && (manual_sel != sel_q)) begin
                    state_d = ST_DRAIN;
                    tgt_d   = manual_sel;
                end
`ifdef REDUND_REVERT_EN
                else if ((sel_q != '0) && link[0]) begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                    if (tmr_exp) begin
                        state_d = ST_DRAIN;
                        tgt_d   = '0;
                    end
                end
`endif
            end
            ST_HOLD: begin
                if (sel_up) begin
                    state_d = ST_ACTIVE;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                    if (tmr_exp) begin
                        if (cand_any) begin
                            state_d = ST_DRAIN;
                            tgt_d   = cand;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (tgt_lost) begin
                    if (cand_any) begin
                        tgt_d = cand;
                    end else if (sel_up) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!busy) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                state_d = ST_ACTIVE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the state being entered, so they are
    // valid for the whole residency of that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            sel_q      <= '0;
            onehot_q   <= '0;
            fifo_rst_q <= '1;
            no_link_q  <= 1'b1;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            no_link_q <= ~|link;
            pulse_q   <= 1'b0;
            case (state_d)
                ST_SWITCH: begin
                    sel_q      <= tgt_d;
                    onehot_q   <= to_onehot(tgt_d);
                    fifo_rst_q <= '1;
                    pulse_q    <= 1'b1;
                    if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
                end
                ST_IDLE: begin
                    onehot_q   <= '0;
                    fifo_rst_q <= '1;
                end
                default: begin
                    fifo_rst_q <= ~onehot_q;
                end
            endcase
        end
    end

    assign sel          = sel_q;
    assign sel_onehot   = onehot_q;
    assign fifo_rst     = fifo_rst_q;
    assign no_link      = no_link_q;
    assign switch_pulse = pulse_q;
    assign switch_cnt   = cnt_q;

endmodule

// File: tb/tb_redund_port_sel.sv
// Directed bench for redund_port_sel with NUM_PORTS=3, HOLDOFF_CYCLES=16.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Revert expectations follow REDUND_REVERT_EN.
module tb_redund_port_sel;

    localparam int NP = 3;
    localparam int SW = 3;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] link;
    logic          busy;
    logic          manual_en;
    logic [SW-1:0] manual_sel;
    logic [SW-1:0] sel;
    logic [NP-1:0] sel_onehot;
    logic [NP-1:0] fifo_rst;
    logic          no_link;
    logic          switch_pulse;
    logic [CW-1:0] switch_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;
    int p0;

    redund_port_sel #(
        .NUM_PORTS      (NP),
        .SEL_W          (SW),
        .HOLDOFF_CYCLES (16),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link         (link),
        .busy         (busy),
        .manual_en    (manual_en),
        .manual_sel   (manual_sel),
        .sel          (sel),
        .sel_onehot   (sel_onehot),
        .fifo_rst     (fifo_rst),
        .no_link      (no_link),
        .switch_pulse (switch_pulse),
        .switch_cnt   (switch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && switch_pulse) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        link       = 3'b011;
        busy       = 1'b0;
        manual_en  = 1'b0;
        manual_sel = '0;
        tick(2);

        // Reset values
        chk("rst_sel",    32'(sel),          32'd0);
        chk("rst_onehot", 32'(sel_onehot),   32'b000);
        chk("rst_fifo",   32'(fifo_rst),     32'b111);
        chk("rst_nolink", 32'(no_link),      32'd1);
        chk("rst_pulse",  32'(switch_pulse), 32'd0);
        chk("rst_cnt",    32'(switch_cnt),   32'd0);

        // 1: first link-up selects port 0 via a SWITCH cycle
        rst_n = 1'b1;
        tick(1);
        chk("t1_sw_pulse", 32'(switch_pulse), 32'd1);
        chk("t1_sw_fifo",  32'(fifo_rst),     32'b111);
        tick(1);
        chk("t1_sel",    32'(sel),        32'd0);
        chk("t1_onehot", 32'(sel_onehot), 32'b001);
        chk("t1_fifo",   32'(fifo_rst),   32'b110);
        chk("t1_cnt",    32'(switch_cnt), 32'd1);
        chk("t1_nolink", 32'(no_link),    32'd0);

        // 2: short link glitch is debounced away
        p0 = pulses;
        link = 3'b010;
        tick(10);
        link = 3'b011;
        tick(3);
        chk("t2_sel",    32'(sel),        32'd0);
        chk("t2_cnt",    32'(switch_cnt), 32'd1);
        chk("t2_fifo",   32'(fifo_rst),   32'b110);
        chk("t2_pulses", 32'(pulses - p0), 32'd0);

        // 3: permanent loss with a frame in flight waits for busy=0
        p0 = pulses;
        busy = 1'b1;
        link = 3'b010;
        tick(25);
        chk("t3_drain_sel",  32'(sel),      32'd0);
        chk("t3_drain_fifo", 32'(fifo_rst), 32'b110);
        busy = 1'b0;
        tick(1);
        chk("t3_sw_sel",   32'(sel),          32'd1);
        chk("t3_sw_fifo",  32'(fifo_rst),     32'b111);
        chk("t3_sw_pulse", 32'(switch_pulse), 32'd1);
        chk("t3_sw_cnt",   32'(switch_cnt),   32'd2);
        tick(1);
        chk("t3_fifo",   32'(fifo_rst),     32'b101);
        chk("t3_onehot", 32'(sel_onehot),   32'b010);
        chk("t3_pulse",  32'(switch_pulse), 32'd0);
        chk("t3_pulses", 32'(pulses - p0),  32'd1);

        // 4: all links down -> IDLE after holdoff, then recovery on port 2
        link = 3'b000;
        tick(1);
        chk("t4_nolink_early", 32'(no_link), 32'd1);
        tick(15);
        chk("t4_hold_fifo", 32'(fifo_rst), 32'b101);
        tick(1);
        chk("t4_idle_fifo",   32'(fifo_rst),   32'b111);
        chk("t4_idle_onehot", 32'(sel_onehot), 32'b000);
        chk("t4_idle_nolink", 32'(no_link),    32'd1);
        link = 3'b100;
        tick(1);
        chk("t4_sel",    32'(sel),        32'd2);
        chk("t4_onehot", 32'(sel_onehot), 32'b100);
        chk("t4_cnt",    32'(switch_cnt), 32'd3);
        chk("t4_nolink", 32'(no_link),    32'd0);
        tick(1);
        chk("t4_fifo", 32'(fifo_rst), 32'b011);

        // 5: manual moves, gated by busy; out-of-range request ignored
        link       = 3'b111;
        manual_en  = 1'b1;
        manual_sel = 3'd0;
        tick(2);
        chk("t5_to0_sel", 32'(sel),        32'd0);
        chk("t5_to0_cnt", 32'(switch_cnt), 32'd4);
        tick(1);
        busy       = 1'b1;
        manual_sel = 3'd2;
        tick(4);
        chk("t5_busy_sel", 32'(sel), 32'd0);
        busy = 1'b0;
        tick(1);
        chk("t5_to2_sel", 32'(sel),        32'd2);
        chk("t5_to2_cnt", 32'(switch_cnt), 32'd5);
        manual_sel = 3'd5;
        tick(5);
        chk("t5_bad_sel",    32'(sel),        32'd2);
        chk("t5_bad_cnt",    32'(switch_cnt), 32'd5);
        chk("t5_bad_onehot", 32'(sel_onehot), 32'b100);
        manual_en = 1'b0;

        // 6: fail over to port 1, then port 0 comes back
        link = 3'b010;
        tick(20);
        chk("t6_sel1", 32'(sel),        32'd1);
        chk("t6_cnt6", 32'(switch_cnt), 32'd6);
        link = 3'b011;
        tick(10);
        link = 3'b010;
        tick(1);
        link = 3'b011;
        tick(12);
        chk("t6_restart_sel", 32'(sel), 32'd1);
        tick(8);
`ifdef REDUND_REVERT_EN
        chk("t6_revert_sel", 32'(sel),        32'd0);
        chk("t6_revert_cnt", 32'(switch_cnt), 32'd7);
`else
        chk("t6_stay_sel", 32'(sel),        32'd1);
        chk("t6_stay_cnt", 32'(switch_cnt), 32'd6);
`endif

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sel",    32'(sel),        32'd0);
        chk("arst_fifo",   32'(fifo_rst),   32'b111);
        chk("arst_nolink", 32'(no_link),    32'd1);
        chk("arst_cnt",    32'(switch_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
